// File: rtl/mmio_ram_pkg.sv
// mmio_ram_pkg: shared constants for the memory-mapped RAM block.
//   - Register offsets relative to IO_BASE (STATUS, ACTION, ACK, IN0, OUT0)
//   - Bit positions inside the STATUS word
//   - State encoding of the clear engine
package mmio_ram_pkg;

  localparam int unsigned OFF_STATUS = 0;
  localparam int unsigned OFF_ACTION = 1;
  localparam int unsigned OFF_ACK    = 2;
  localparam int unsigned OFF_IN0    = 3;

  // The output block follows the input ports, so its offset depends on N_IN.
  function automatic int unsigned off_out0(input int unsigned n_in);
    return OFF_IN0 + n_in;
  endfunction

  localparam int unsigned STAT_PENDING  = 0;
  localparam int unsigned STAT_BUSY     = 1;
  localparam int unsigned STAT_OVERFLOW = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/mmio_ram_clear.sv
// mmio_ram_clear: RAM clear engine.
//   Walks cnt from 0 to IO_BASE-1, asserting wr_en each cycle so the parent
//   writes the fill value at mem[cnt]. A clr request (in either state)
//   restarts the walk at 0. Reset leaves the engine in CLEAR so the RAM is
//   filled automatically after power-up.
// Ports:
//   CLK, RESET  clock, asynchronous active-high reset
//   clr         restart request
//   busy        high while in CLEAR
//   cnt         word address being cleared
//   wr_en       write strobe for mem[cnt]
module mmio_ram_clear
  import mmio_ram_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int IO_BASE = 245
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              clr,
  output logic              busy,
  output logic [ADDR_W-1:0] cnt,
  output logic              wr_en
);

  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(IO_BASE - 1);

  clr_state_e        state, state_nxt;
  logic [ADDR_W-1:0] cnt_nxt;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= ST_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    busy      = 1'b0;
    wr_en     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (clr) begin
          state_nxt = ST_CLEAR;
          cnt_nxt   = '0;
        end
      end
      ST_CLEAR: begin
        busy  = 1'b1;
        wr_en = 1'b1;
        // A fresh request wins over the end of the current pass.
        if (clr) begin
          cnt_nxt = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + ADDR_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/mmio_ram.sv
// mmio_ram: CPU-visible RAM with a memory-mapped I/O block at the top of the
// address space, an action mailbox, an ack register and a clear engine.
// Ports:
//   CLK, RESET         clock, asynchronous active-high reset
//   ADDR, DATA, MW     CPU address, write data, write enable
//   RD                 read strobe (only for read side effects)
//   Q                  combinational read data
//   io_in / io_out     packed input ports / output registers
//   act_data/act_valid action word into the mailbox
//   ack, ack_stb       last ack value and its one-cycle strobe
//   clr, busy          clear request / clear engine running
//   dispMsg            display window, word 0 at the MSB end
module mmio_ram
  import mmio_ram_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int N_IN      = 2,
  parameter int N_OUT     = 6,
  parameter int DISP_BASE = 64,
  parameter int DISP_LEN  = 64,
  parameter logic [DATA_W-1:0] FILL = DATA_W'(8'h30)
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic [ADDR_W-1:0]            ADDR,
  input  logic [DATA_W-1:0]            DATA,
  input  logic                         MW,
  input  logic                         RD,
  output logic [DATA_W-1:0]            Q,
  input  logic [N_IN*DATA_W-1:0]       io_in,
  output logic [N_OUT*DATA_W-1:0]      io_out,
  input  logic [DATA_W-1:0]            act_data,
  input  logic                         act_valid,
  output logic [DATA_W-1:0]            ack,
  output logic                         ack_stb,
  input  logic                         clr,
  output logic                         busy,
  output logic [0:DISP_LEN*DATA_W-1]   dispMsg
);

  localparam int N_IO     = N_IN + N_OUT + 3;
  localparam int IO_BASE  = (2 ** ADDR_W) - N_IO;
  localparam int OUT0_OFF = int'(off_out0(N_IN));

  localparam logic [ADDR_W-1:0] A_IO     = ADDR_W'(IO_BASE);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(IO_BASE + OFF_STATUS);
  localparam logic [ADDR_W-1:0] A_ACTION = ADDR_W'(IO_BASE + OFF_ACTION);
  localparam logic [ADDR_W-1:0] A_ACK    = ADDR_W'(IO_BASE + OFF_ACK);

  if (DISP_BASE + DISP_LEN > IO_BASE) begin : g_bad_disp
    $error("mmio_ram: display window overlaps the I/O block");
  end

  logic [DATA_W-1:0] mem [0:IO_BASE-1];

  logic              clr_wr_en;
  logic [ADDR_W-1:0] clr_cnt;
  logic              pending, overflow;
  logic [DATA_W-1:0] mbox;
  logic              ram_sel, rd_action, rd_status;
  logic [DATA_W-1:0] q_c;

  mmio_ram_clear #(
    .ADDR_W (ADDR_W),
    .IO_BASE(IO_BASE)
  ) u_clear (
    .CLK  (CLK),
    .RESET(RESET),
    .clr  (clr),
    .busy (busy),
    .cnt  (clr_cnt),
    .wr_en(clr_wr_en)
  );

  assign ram_sel   = (ADDR < A_IO);
  assign rd_action = RD && (ADDR == A_ACTION);
  assign rd_status = RD && (ADDR == A_STATUS);

  // The clear engine owns the write port while running; CPU writes are dropped.
  always_ff @(posedge CLK) begin
    if (clr_wr_en) begin
      mem[clr_cnt] <= FILL;
    end else if (MW && ram_sel) begin
      mem[ADDR] <= DATA;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      io_out   <= '0;
      ack      <= '0;
      ack_stb  <= 1'b0;
      pending  <= 1'b0;
      overflow <= 1'b0;
      mbox     <= '0;
    end else begin
      ack_stb <= MW && (ADDR == A_ACK);
      if (MW && (ADDR == A_ACK)) begin
        ack <= DATA;
      end
      for (int k = 0; k < N_OUT; k++) begin
        if (MW && (ADDR == ADDR_W'(IO_BASE + OUT0_OFF + k))) begin
          io_out[k*DATA_W +: DATA_W] <= DATA;
        end
      end
      // New data always wins over a same-cycle read-clear; that overlap is
      // not an overrun, so overflow only sets when nobody consumed the word.
      if (act_valid) begin
        mbox    <= act_data;
        pending <= 1'b1;
        if (pending && !rd_action) begin
          overflow <= 1'b1;
        end
      end else if (rd_action) begin
        pending <= 1'b0;
      end
      if (rd_status) begin
        overflow <= 1'b0;
      end
    end
  end

  always_comb begin
    q_c = '0;
    if (ram_sel) begin
      if (!busy) begin
        q_c = mem[ADDR];
      end
    end else if (ADDR == A_STATUS) begin
      q_c[STAT_PENDING]  = pending;
      q_c[STAT_BUSY]     = busy;
      q_c[STAT_OVERFLOW] = overflow;
    end else if (ADDR == A_ACTION) begin
      q_c = mbox;
    end else begin
      for (int k = 0; k < N_IN; k++) begin
        if (ADDR == ADDR_W'(IO_BASE + int'(OFF_IN0) + k)) begin
          q_c = io_in[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign Q = q_c;

  for (genvar i = 0; i < DISP_LEN; i++) begin : g_disp
    assign dispMsg[i*DATA_W +: DATA_W] = mem[DISP_BASE + i];
  end

endmodule

// File: tb/tb_mmio_ram.sv
module tb_mmio_ram;

  localparam int IOB  = 245;
  localparam logic [7:0] FILLV = 8'h30;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic [7:0]   ADDR = '0;
  logic [7:0]   DATA = '0;
  logic         MW = 1'b0;
  logic         RD = 1'b0;
  logic [7:0]   Q;
  logic [15:0]  io_in = '0;
  logic [47:0]  io_out;
  logic [7:0]   act_data = '0;
  logic         act_valid = 1'b0;
  logic [7:0]   ack;
  logic         ack_stb;
  logic         clr = 1'b0;
  logic         busy;
  logic [0:511] dispMsg;

  mmio_ram dut (
    .CLK(CLK), .RESET(RESET), .ADDR(ADDR), .DATA(DATA), .MW(MW), .RD(RD),
    .Q(Q), .io_in(io_in), .io_out(io_out), .act_data(act_data),
    .act_valid(act_valid), .ack(ack), .ack_stb(ack_stb), .clr(clr),
    .busy(busy), .dispMsg(dispMsg)
  );

  always #5 CLK = ~CLK;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  q;
    logic        busy;
    logic [7:0]  ack;
    logic        stb;
    logic [47:0] io_out;
    int          di;
    logic [7:0]  disp;
    bit          disp_known;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  bit   chk   = 0;

  // Reference model: plain arrays and counters describing the visible state.
  logic [7:0] ram [IOB];
  bit         known [IOB];
  logic [7:0] m_io [6];
  logic [7:0] m_ack, m_mbox;
  logic       m_stb, m_pend, m_ovf;
  int         clear_left;

  task automatic cmp(input string nm, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, a, e, $time);
    end
  endtask

  function automatic void m_reset();
    for (int k = 0; k < 6; k++) m_io[k] = '0;
    m_ack = '0; m_stb = 1'b0; m_pend = 1'b0; m_ovf = 1'b0; m_mbox = '0;
    clear_left = IOB;
  endfunction

  function automatic logic [7:0] exp_q(input int a);
    logic [7:0] r = '0;
    if (a < IOB) r = (clear_left > 0) ? 8'h00 : ram[a];
    else if (a == IOB) r = {5'b0, m_ovf, (clear_left > 0), m_pend};
    else if (a == IOB + 1) r = m_mbox;
    else if (a == IOB + 3) r = io_in[7:0];
    else if (a == IOB + 4) r = io_in[15:8];
    return r;
  endfunction

  function automatic void m_update(input int a, input logic [7:0] d, input logic mw,
                                   input logic rd, input logic av, input logic [7:0] ad,
                                   input logic cl);
    bit busy_now = (clear_left > 0);
    bit rd_act = rd && (a == IOB + 1);
    bit rd_st  = rd && (a == IOB);
    if (busy_now) begin
      ram[IOB - clear_left] = FILLV;
      known[IOB - clear_left] = 1;
    end else if (mw && a < IOB) begin
      ram[a] = d;
      known[a] = 1;
    end
    if (cl) clear_left = IOB;
    else if (busy_now) clear_left--;
    m_stb = mw && (a == IOB + 2);
    if (m_stb) m_ack = d;
    if (mw && a >= IOB + 5) m_io[a - (IOB + 5)] = d;
    if (av) begin
      if (m_pend && !rd_act) m_ovf = 1'b1;
      m_mbox = ad;
      m_pend = 1'b1;
    end else if (rd_act) begin
      m_pend = 1'b0;
    end
    if (rd_st) m_ovf = 1'b0;
  endfunction

  // One bus cycle: drive just after the edge, queue what the outputs must
  // show for the rest of this cycle, then advance the model past the next edge.
  task automatic step(input int a, input logic [7:0] d, input logic mw, input logic rd,
                      input logic av, input logic [7:0] ad, input logic cl, input logic rs);
    exp_t e;
    @(posedge CLK);
    #1;
    ADDR = 8'(a); DATA = d; MW = mw; RD = rd;
    act_valid = av; act_data = ad; clr = cl; RESET = rs;
    io_in = 16'($urandom);
    if (rs) m_reset();
    e.q    = exp_q(a);
    e.busy = (clear_left > 0);
    e.ack  = m_ack;
    e.stb  = m_stb;
    for (int k = 0; k < 6; k++) e.io_out[k*8 +: 8] = m_io[k];
    e.di = $urandom_range(0, 63);
    e.disp = ram[64 + e.di];
    e.disp_known = known[64 + e.di];
    sb.push_back(e);
    chk = 1;
    if (!rs) m_update(a, d, mw, rd, av, ad, cl);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    step(a, d, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic rdq(input int a, input logic rd);
    step(a, 8'h00, 1'b0, rd, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  function automatic int rand_addr();
    int r = $urandom_range(0, 9);
    if (r <= 2) return $urandom_range(0, 63);
    if (r <= 5) return $urandom_range(64, 127);
    if (r <= 7) return $urandom_range(IOB, 255);
    if (r == 8) return $urandom_range(128, IOB - 1);
    return $urandom_range(0, 255);
  endfunction

  // Monitor: every checked cycle pops one expectation and compares outputs.
  always @(negedge CLK) begin
    if (chk) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL scoreboard: output cycle with no expectation at %0t", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        cmp("Q", 64'(Q), 64'(e.q));
        cmp("busy", 64'(busy), 64'(e.busy));
        cmp("ack", 64'(ack), 64'(e.ack));
        cmp("ack_stb", 64'(ack_stb), 64'(e.stb));
        cmp("io_out", 64'(io_out), 64'(e.io_out));
        if (e.disp_known) cmp("dispMsg", 64'(dispMsg[e.di*8 +: 8]), 64'(e.disp));
      end
    end
  end

  initial begin
    for (int i = 0; i < IOB; i++) begin ram[i] = '0; known[i] = 0; end
    m_reset();

    // Power-up: reset, then the automatic fill.
    for (int i = 0; i < 3; i++) step(0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    idle(250);
    for (int a = 0; a < IOB; a++) rdq(a, 1'b0);

    // Display window write and read-back.
    wr(64, 8'h58);
    rdq(64, 1'b0);
    idle(1);

    // Mailbox overrun, then overflow cleared by a STATUS read.
    step(0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h05, 1'b0, 1'b0);
    step(0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h07, 1'b0, 1'b0);
    rdq(IOB, 1'b0);
    rdq(IOB + 1, 1'b0);
    rdq(IOB, 1'b1);
    rdq(IOB, 1'b0);

    // New action in the same cycle as the ACTION read-clear.
    step(IOB + 1, 8'h00, 1'b0, 1'b1, 1'b1, 8'h09, 1'b0, 1'b0);
    rdq(IOB, 1'b0);
    rdq(IOB + 1, 1'b1);
    rdq(IOB, 1'b0);

    // Ack, output register, and a write to a read-only input port.
    wr(IOB + 2, 8'hAA);
    idle(2);
    wr(IOB + 5, 8'h11);
    wr(IOB + 3, 8'h77);
    rdq(IOB + 3, 1'b0);
    wr(255, 8'hC3);
    idle(1);

    // Clear request, then a RAM write dropped at cycle 5 of the fill.
    wr(10, 8'h5A);
    step(0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    idle(4);
    wr(10, 8'h55);
    idle(245);
    rdq(10, 1'b0);

    // Restart while clearing, then reset in the middle of a fill.
    step(0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    idle(30);
    step(0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    idle(60);
    wr(IOB + 6, 8'h42);
    for (int i = 0; i < 2; i++) step(0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    idle(250);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      step(rand_addr(), 8'($urandom), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 1) == 1), ($urandom_range(0, 7) == 0),
           8'($urandom), ($urandom_range(0, 299) == 0), 1'b0);
    end
    idle(2);

    @(negedge CLK);
    #1;
    cmp("scoreboard_drain", 64'(sb.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
